// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one backing memory port between the fetch stage (imem, read-only) and
// the data memory stage (dmem, read/write). Both sides use the mask-pulse
// protocol: a nonzero rmask/wmask held for one cycle is a request, and a
// one-cycle resp marks its completion.
//
// Each requester owns one pending slot. A request is written into its slot on
// the edge where it arrives. While the backing port is idle, the arbiter picks
// a winner from the pending slots and any request arriving in the same cycle.
// It loads the bmem_* registers with the winner's request and clears that
// slot. Only one access is in flight at a time. The backing response is routed
// combinationally to the requester that owns the in-flight access.
//
// Parameters
//   DMEM_PRIORITY  1: dmem wins ties, 0: imem wins ties
//   CNT_WIDTH      width of conflict_count
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   imem_addr/rmask           fetch request (read only)
//   imem_rdata/resp           fetch completion, rdata valid with resp
//   dmem_addr/rmask/wmask/
//     wdata                   data request (read or write)
//   dmem_rdata/resp           data completion, rdata valid with resp
//   bmem_addr/rmask/wmask/
//     wdata                   backing request; masks are one-cycle pulses,
//                             addr/wdata hold until the next issue
//   bmem_rdata/resp           backing completion
//   conflict_count            saturating count of cycles in which a pending
//                             request was left waiting
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter bit DMEM_PRIORITY = 1'b1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic [31:0]          imem_addr,
  input  logic [3:0]           imem_rmask,
  output logic [31:0]          imem_rdata,
  output logic                 imem_resp,

  input  logic [31:0]          dmem_addr,
  input  logic [3:0]           dmem_rmask,
  input  logic [3:0]           dmem_wmask,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output logic                 dmem_resp,

  output logic [31:0]          bmem_addr,
  output logic [3:0]           bmem_rmask,
  output logic [3:0]           bmem_wmask,
  output logic [31:0]          bmem_wdata,
  input  logic [31:0]          bmem_rdata,
  input  logic                 bmem_resp,

  output logic [CNT_WIDTH-1:0] conflict_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  // One captured request. An imem request always carries zero wmask/wdata.
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e               state_q, state_d;

  logic                 i_pend_q, i_pend_d;
  req_t                 i_slot_q, i_slot_d;
  logic                 d_pend_q, d_pend_d;
  req_t                 d_slot_q, d_slot_d;

  logic [31:0]          bmem_addr_q,  bmem_addr_d;
  logic [3:0]           bmem_rmask_q, bmem_rmask_d;
  logic [3:0]           bmem_wmask_q, bmem_wmask_d;
  logic [31:0]          bmem_wdata_q, bmem_wdata_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // ---------------------------------------------------------------------------
  // Incoming requests and arbitration
  // ---------------------------------------------------------------------------
  logic i_arrive, d_arrive;
  logic i_avail,  d_avail;
  logic issue_i,  issue_d;
  req_t i_in, d_in;
  req_t i_cand, d_cand;

  assign i_arrive = |imem_rmask;
  assign d_arrive = (|dmem_rmask) | (|dmem_wmask);

  assign i_in = {imem_addr, imem_rmask, 4'b0000, 32'h0000_0000};
  assign d_in = {dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata};

  // A requester never has a pending slot and a new arrival at the same time,
  // so whichever one is present is that requester's candidate.
  assign i_avail = i_pend_q | i_arrive;
  assign d_avail = d_pend_q | d_arrive;
  assign i_cand  = i_pend_q ? i_slot_q : i_in;
  assign d_cand  = d_pend_q ? d_slot_q : d_in;

  // Issue happens only from IDLE. On a tie, DMEM_PRIORITY picks the winner.
  assign issue_d = (state_q == IDLE) && d_avail && (DMEM_PRIORITY || !i_avail);
  assign issue_i = (state_q == IDLE) && i_avail && !issue_d;

  // ---------------------------------------------------------------------------
  // Pending slots: an arrival is always captured. If the same edge issues it,
  // the slot is left empty again.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    i_pend_d = i_pend_q;
    i_slot_d = i_slot_q;
    d_pend_d = d_pend_q;
    d_slot_d = d_slot_q;

    if (i_arrive) begin
      i_pend_d = 1'b1;
      i_slot_d = i_in;
    end
    if (issue_i) begin
      i_pend_d = 1'b0;
    end

    if (d_arrive) begin
      d_pend_d = 1'b1;
      d_slot_d = d_in;
    end
    if (issue_d) begin
      d_pend_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and backing-port registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    bmem_addr_d  = bmem_addr_q;
    bmem_wdata_d = bmem_wdata_q;
    bmem_rmask_d = 4'b0000;     // the masks are pulses: zero unless issuing
    bmem_wmask_d = 4'b0000;

    unique case (state_q)
      IDLE: begin
        if (issue_d) begin
          state_d      = BUSY_D;
          bmem_addr_d  = d_cand.addr;
          bmem_rmask_d = d_cand.rmask;
          bmem_wmask_d = d_cand.wmask;
          bmem_wdata_d = d_cand.wdata;
        end else if (issue_i) begin
          state_d      = BUSY_I;
          bmem_addr_d  = i_cand.addr;
          bmem_rmask_d = i_cand.rmask;
          bmem_wmask_d = i_cand.wmask;
          bmem_wdata_d = i_cand.wdata;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bmem_resp) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Conflict counter: counts each cycle in which a request was already waiting
  // in a slot and this edge did not issue it. Arrivals that come in this cycle
  // are not counted yet. The counter stops at all-ones.
  // ---------------------------------------------------------------------------
  logic waiting;

  assign waiting = (i_pend_q && !issue_i) || (d_pend_q && !issue_d);

  always_comb begin
    cnt_d = cnt_q;
    if (waiting && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset abandons any in-flight access and drops both slots.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    if (rst) begin
      state_q      <= IDLE;
      i_pend_q     <= 1'b0;
      i_slot_q     <= '0;
      d_pend_q     <= 1'b0;
      d_slot_q     <= '0;
      bmem_addr_q  <= '0;
      bmem_rmask_q <= '0;
      bmem_wmask_q <= '0;
      bmem_wdata_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      i_pend_q     <= i_pend_d;
      i_slot_q     <= i_slot_d;
      d_pend_q     <= d_pend_d;
      d_slot_q     <= d_slot_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_rmask_q <= bmem_rmask_d;
      bmem_wmask_q <= bmem_wmask_d;
      bmem_wdata_q <= bmem_wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The response path is combinational so that the owner sees the
  // response in the same cycle as bmem_resp. A bmem_resp that arrives while
  // IDLE belongs to no one and is dropped.
  // ---------------------------------------------------------------------------
  assign imem_resp  = (state_q == BUSY_I) && bmem_resp;
  assign dmem_resp  = (state_q == BUSY_D) && bmem_resp;
  assign imem_rdata = imem_resp ? bmem_rdata : 32'h0000_0000;
  assign dmem_rdata = dmem_resp ? bmem_rdata : 32'h0000_0000;

  assign bmem_addr      = bmem_addr_q;
  assign bmem_rmask     = bmem_rmask_q;
  assign bmem_wmask     = bmem_wmask_q;
  assign bmem_wdata     = bmem_wdata_q;
  assign conflict_count = cnt_q;

endmodule
